// File: rtl/collision_detector.sv
// ---------------------------------------------------------------------------
// collision_detector
//
// Watches the pixel stream during scan-out and counts pixels where the
// player dot overlaps a hexagon wall. At each frame boundary (rising edge of
// VGA_VS) the count is evaluated. Enough consecutive "hit" frames outside the
// start-of-run grace window latch a sticky game_over for the game FSM.
//
// Optional feature macro: SURVIVAL_TIMER_EN
//   defined   : survival_frames counts frames survived in the current run
//   undefined : survival_frames is tied to zero
//
// Ports
//   Clk             in   1   system clock
//   Reset_h         in   1   synchronous active-high reset
//   DrawX           in  10   current pixel column
//   DrawY           in  10   current pixel row
//   VGA_VS          in   1   vertical sync (asynchronous), rise = frame boundary
//   State           in   3   game state: 1-3 playing, anything else menu
//   is_player       in   1   pixel belongs to the player dot
//   is_wall         in   1   pixel belongs to a wall
//   frame_hit       out  1   one-cycle pulse, evaluated frame was a hit
//   game_over       out  1   sticky collision verdict
//   overlap_cnt     out 12   overlap count of the last evaluated frame
//   survival_frames out 16   frames survived in the current run
// ---------------------------------------------------------------------------
module collision_detector #(
    parameter int HIT_THRESHOLD = 4,
    parameter int HIT_FRAMES    = 2,
    parameter int GRACE_FRAMES  = 30
) (
    input  logic        Clk,
    input  logic        Reset_h,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        VGA_VS,
    input  logic [2:0]  State,
    input  logic        is_player,
    input  logic        is_wall,
    output logic        frame_hit,
    output logic        game_over,
    output logic [11:0] overlap_cnt,
    output logic [15:0] survival_frames
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRACE = 2'd1,
        PLAY  = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam int          GRACE_LAST_I = (GRACE_FRAMES > 0) ? GRACE_FRAMES - 1 : 0;
    localparam logic [15:0] GRACE_LAST   = GRACE_LAST_I[15:0];
    localparam int          HIT_LAST_I   = (HIT_FRAMES > 1) ? HIT_FRAMES - 1 : 0;
    localparam logic [7:0]  HIT_LAST     = HIT_LAST_I[7:0];
    localparam logic [12:0] HIT_THR      = HIT_THRESHOLD[12:0];

    state_t       state_r;
    state_t       state_nxt_s;

    logic         vs_meta_r;
    logic         vs_sync_r;
    logic         vs_prev_r;
    logic         vs_rise_r;
    logic [2:0]   vs_vld_r;

    logic [19:0]  pix_prev_r;
    logic         pix_new_s;
    logic         pix_vis_s;
    logic         hit_pix_s;

    logic [11:0]  acc_r;
    logic [11:0]  acc_inc_s;
    logic [15:0]  grace_cnt_r;
    logic [7:0]   hit_run_r;
    logic         frame_hit_r;
    logic         game_over_r;
    logic [11:0]  overlap_cnt_r;

    logic         playing_s;
    logic         frame_is_hit_s;
    logic         eval_s;

    // Game state 1..3 means a level is being played
    always_comb begin
        playing_s = 1'b0;
        if ((State[2] == 1'b0) && (State[1:0] != 2'd0)) begin
            playing_s = 1'b1;
        end else begin
            playing_s = 1'b0;
        end
    end

    // VGA_VS synchroniser and registered rising-edge detector. vs_vld_r
    // suppresses the edge until prev holds a genuine post-reset sample.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            vs_meta_r <= 1'b0;
            vs_sync_r <= 1'b0;
            vs_prev_r <= 1'b0;
            vs_rise_r <= 1'b0;
            vs_vld_r  <= 3'd0;
        end else begin
            vs_meta_r <= VGA_VS;
            vs_sync_r <= vs_meta_r;
            vs_prev_r <= vs_sync_r;
            vs_vld_r  <= {vs_vld_r[1:0], 1'b1};
            vs_rise_r <= vs_vld_r[2] & vs_sync_r & ~vs_prev_r;
        end
    end

    // Previous pixel coordinate, used to count each pixel once when the
    // system clock runs faster than the pixel clock
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            pix_prev_r <= 20'd0;
        end else begin
            pix_prev_r <= {DrawX, DrawY};
        end
    end

    // Pixel qualification and frame evaluation terms
    always_comb begin
        pix_new_s      = ({DrawX, DrawY} != pix_prev_r);
        pix_vis_s      = (DrawX < 10'd640) && (DrawY < 10'd480);
        hit_pix_s      = pix_new_s & pix_vis_s & is_player & is_wall;
        acc_inc_s      = (acc_r == 12'hFFF) ? acc_r : (acc_r + 12'd1);
        frame_is_hit_s = ({1'b0, acc_r} >= HIT_THR);
        eval_s         = (state_r == PLAY) && playing_s && vs_rise_r;
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; leaving levels 1..3 always returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (playing_s) begin
                    state_nxt_s = (GRACE_FRAMES == 0) ? PLAY : GRACE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRACE: begin
                if (!playing_s) begin
                    state_nxt_s = IDLE;
                end else if (vs_rise_r && (grace_cnt_r == GRACE_LAST)) begin
                    state_nxt_s = PLAY;
                end else begin
                    state_nxt_s = GRACE;
                end
            end
            PLAY: begin
                if (!playing_s) begin
                    state_nxt_s = IDLE;
                end else if (vs_rise_r && frame_is_hit_s && (hit_run_r >= HIT_LAST)) begin
                    state_nxt_s = DEAD;
                end else begin
                    state_nxt_s = PLAY;
                end
            end
            DEAD: begin
                if (!playing_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DEAD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Overlap accumulator, grace counter, hit run and verdict registers.
    // On a frame boundary the pixel of that same cycle starts the new frame.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            acc_r         <= 12'd0;
            grace_cnt_r   <= 16'd0;
            hit_run_r     <= 8'd0;
            frame_hit_r   <= 1'b0;
            game_over_r   <= 1'b0;
            overlap_cnt_r <= 12'd0;
        end else begin
            frame_hit_r <= eval_s & frame_is_hit_s;
            case (state_r)
                IDLE: begin
                    acc_r       <= 12'd0;
                    grace_cnt_r <= 16'd0;
                    hit_run_r   <= 8'd0;
                    game_over_r <= 1'b0;
                end
                GRACE: begin
                    if (!playing_s) begin
                        acc_r <= 12'd0;
                    end else if (vs_rise_r) begin
                        acc_r       <= hit_pix_s ? 12'd1 : 12'd0;
                        grace_cnt_r <= grace_cnt_r + 16'd1;
                    end else if (hit_pix_s) begin
                        acc_r <= acc_inc_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                PLAY: begin
                    if (!playing_s) begin
                        acc_r     <= 12'd0;
                        hit_run_r <= 8'd0;
                    end else if (vs_rise_r) begin
                        overlap_cnt_r <= acc_r;
                        acc_r         <= hit_pix_s ? 12'd1 : 12'd0;
                        if (frame_is_hit_s) begin
                            hit_run_r <= (hit_run_r == 8'hFF) ? hit_run_r : (hit_run_r + 8'd1);
                            if (hit_run_r >= HIT_LAST) begin
                                game_over_r <= 1'b1;
                            end else begin
                                game_over_r <= game_over_r;
                            end
                        end else begin
                            hit_run_r <= 8'd0;
                        end
                    end else if (hit_pix_s) begin
                        acc_r <= acc_inc_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                DEAD: begin
                    if (!playing_s) begin
                        acc_r       <= 12'd0;
                        hit_run_r   <= 8'd0;
                        game_over_r <= 1'b0;
                    end else begin
                        game_over_r <= 1'b1;
                    end
                end
                default: begin
                    acc_r <= 12'd0;
                end
            endcase
        end
    end

`ifdef SURVIVAL_TIMER_EN
    logic [15:0] surv_r;

    // Frames survived: cleared when a run starts, frozen in DEAD, held in IDLE
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            surv_r <= 16'd0;
        end else if ((state_r == IDLE) && (state_nxt_s != IDLE)) begin
            surv_r <= 16'd0;
        end else if (vs_rise_r && playing_s &&
                     ((state_r == GRACE) || (state_r == PLAY)) &&
                     (surv_r != 16'hFFFF)) begin
            surv_r <= surv_r + 16'd1;
        end else begin
            surv_r <= surv_r;
        end
    end

    assign survival_frames = surv_r;
`else
    assign survival_frames = 16'd0;
`endif

    assign frame_hit   = frame_hit_r;
    assign game_over   = game_over_r;
    assign overlap_cnt = overlap_cnt_r;

endmodule

// File: tb/tb_collision_detector.sv
// ---------------------------------------------------------------------------
// tb_collision_detector
// Directed-vector bench for collision_detector with default parameters
// (HIT_THRESHOLD=4, HIT_FRAMES=2, GRACE_FRAMES=30).
// ---------------------------------------------------------------------------
module tb_collision_detector;

    logic        Clk;
    logic        Reset_h;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        VGA_VS;
    logic [2:0]  State;
    logic        is_player;
    logic        is_wall;
    logic        frame_hit;
    logic        game_over;
    logic [11:0] overlap_cnt;
    logic [15:0] survival_frames;

    int n_tests;
    int n_fail;

    collision_detector dut (
        .Clk             (Clk),
        .Reset_h         (Reset_h),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .VGA_VS          (VGA_VS),
        .State           (State),
        .is_player       (is_player),
        .is_wall         (is_wall),
        .frame_hit       (frame_hit),
        .game_over       (game_over),
        .overlap_cnt     (overlap_cnt),
        .survival_frames (survival_frames)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: n_vis overlap pixels (each held 'hold' cycles), a few
    // non-qualifying pixels, then a VS pulse. Reports frame_hit activity.
    task automatic run_frame(input int n_vis, input int hold, input int n_off,
                             output int hits, output int lat, output int go_at_hit);
        hits = 0;
        lat = -1;
        go_at_hit = -1;
        for (int i = 0; i < n_vis; i++) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge Clk);
                DrawX = 10'(10 + i);
                DrawY = 10'd100;
                is_player = 1'b1;
                is_wall = 1'b1;
            end
        end
        for (int i = 0; i < n_off; i++) begin
            @(negedge Clk);
            DrawX = 10'd700;
            DrawY = 10'(100 + i);
            is_player = 1'b1;
            is_wall = 1'b1;
            @(negedge Clk);
            DrawX = 10'(20 + i);
            DrawY = 10'd480;
            @(negedge Clk);
            DrawX = 10'(300 + i);
            DrawY = 10'd200;
            is_wall = 1'b0;
        end
        @(negedge Clk);
        DrawX = 10'd600;
        DrawY = 10'd400;
        is_player = 1'b0;
        is_wall = 1'b0;
        VGA_VS = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (frame_hit) begin
                hits++;
                if (lat < 0) begin
                    lat = c;
                    go_at_hit = int'(game_over);
                end
            end
        end
        VGA_VS = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    int hits, lat, go_hit, total;

    initial begin
        n_tests = 0;
        n_fail = 0;
        Reset_h = 1'b1;
        DrawX = 10'd600;
        DrawY = 10'd400;
        VGA_VS = 1'b0;
        State = 3'd0;
        is_player = 1'b0;
        is_wall = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_h = 1'b0;
        @(negedge Clk);
        check_eq("rst_frame_hit", int'(frame_hit), 0);
        check_eq("rst_game_over", int'(game_over), 0);
        check_eq("rst_overlap", int'(overlap_cnt), 0);
        check_eq("rst_survival", int'(survival_frames), 0);

        // Grace: 30 frames with 5 overlap pixels never hit
        State = 3'd1;
        total = 0;
        for (int f = 0; f < 30; f++) begin
            run_frame(5, 1, 0, hits, lat, go_hit);
            total += hits;
        end
        check_eq("grace_hits", total, 0);
        check_eq("grace_overlap", int'(overlap_cnt), 0);
        check_eq("grace_go", int'(game_over), 0);

        // Frame 31: first evaluated frame
        run_frame(5, 1, 0, hits, lat, go_hit);
        check_eq("f31_hits", hits, 1);
        check_eq("f31_latency", lat, 4);
        check_eq("f31_overlap", int'(overlap_cnt), 5);
        check_eq("f31_go", int'(game_over), 0);

        // Below threshold clears the run
        run_frame(3, 1, 0, hits, lat, go_hit);
        check_eq("thr3_hits", hits, 0);
        check_eq("thr3_overlap", int'(overlap_cnt), 3);
        check_eq("thr3_go", int'(game_over), 0);

        run_frame(4, 1, 0, hits, lat, go_hit);
        check_eq("thr4a_hits", hits, 1);
        check_eq("thr4a_go", int'(game_over), 0);
        run_frame(4, 1, 0, hits, lat, go_hit);
        check_eq("thr4b_hits", hits, 1);
        check_eq("thr4b_go_at_hit", go_hit, 1);
        check_eq("thr4b_overlap", int'(overlap_cnt), 4);

        // DEAD: accumulator frozen, overlap held, no pulses
        run_frame(10, 1, 0, hits, lat, go_hit);
        check_eq("dead_hits", hits, 0);
        check_eq("dead_overlap", int'(overlap_cnt), 4);
        check_eq("dead_go", int'(game_over), 1);

        // Exit to menu
        @(negedge Clk);
        State = 3'd0;
        repeat (2) @(negedge Clk);
        check_eq("exit_go", int'(game_over), 0);
        check_eq("exit_overlap", int'(overlap_cnt), 4);
`ifdef SURVIVAL_TIMER_EN
        check_eq("exit_survival", int'(survival_frames), 34);
`else
        check_eq("exit_survival", int'(survival_frames), 0);
`endif

        // Non-consecutive hits: 4,0,4,0 never kill
        State = 3'd2;
        for (int f = 0; f < 30; f++) begin
            run_frame(0, 1, 0, hits, lat, go_hit);
        end
        for (int f = 0; f < 4; f++) begin
            run_frame((f % 2 == 0) ? 4 : 0, 1, 0, hits, lat, go_hit);
            check_eq("alt_hits", hits, (f % 2 == 0) ? 1 : 0);
            check_eq("alt_overlap", int'(overlap_cnt), (f % 2 == 0) ? 4 : 0);
            check_eq("alt_go", int'(game_over), 0);
        end

        // Level change keeps the hit run
        run_frame(4, 1, 0, hits, lat, go_hit);
        check_eq("lvl_go_a", int'(game_over), 0);
        State = 3'd3;
        run_frame(4, 1, 0, hits, lat, go_hit);
        check_eq("lvl_go_b", int'(game_over), 1);

        // State 5 is a menu state
        State = 3'd5;
        repeat (2) @(negedge Clk);
        check_eq("menu5_go", int'(game_over), 0);

        // Double-sampled pixels counted once, off-screen pixels ignored
        State = 3'd1;
        for (int f = 0; f < 30; f++) begin
            run_frame(0, 1, 0, hits, lat, go_hit);
        end
        run_frame(6, 2, 3, hits, lat, go_hit);
        check_eq("dbl_overlap", int'(overlap_cnt), 6);
        check_eq("dbl_hits", hits, 1);

        // Reset mid-PLAY with 50 pixels accumulated
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            DrawX = 10'(10 + i);
            DrawY = 10'd50;
            is_player = 1'b1;
            is_wall = 1'b1;
        end
        @(negedge Clk);
        is_player = 1'b0;
        is_wall = 1'b0;
        Reset_h = 1'b1;
        repeat (2) @(negedge Clk);
        Reset_h = 1'b0;
        check_eq("mid_rst_frame_hit", int'(frame_hit), 0);
        check_eq("mid_rst_go", int'(game_over), 0);
        check_eq("mid_rst_overlap", int'(overlap_cnt), 0);
        check_eq("mid_rst_survival", int'(survival_frames), 0);

        // After reset the run restarts in grace: no hit evaluated
        run_frame(5, 1, 0, hits, lat, go_hit);
        check_eq("post_rst_hits", hits, 0);
        check_eq("post_rst_overlap", int'(overlap_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
